// File: rtl/qspi_mem_responder.sv
// QSPI target bridging quad read (0xEB) / write (0x38) transactions onto a
// one-byte synchronous memory port; all QSPI pins are oversampled in clkin.
module qspi_mem_responder #(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 sck,
  input  logic                 ce_n,
  input  logic [3:0]           sio_i,
  output logic [3:0]           sio_o,
  output logic                 sio_en,
  input  logic                 qspi_cmd,
  input  logic [3:0]           dummy,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  state_t r_state, w_next;

  logic       r_sck_s1, r_sck_s2, r_sck_s3;
  logic       r_ce_s1, r_ce_s2, r_ce_s3;
  logic [3:0] r_sio_s1, r_sio_s2;

  logic [6:0]  r_cmd;
  logic [3:0]  r_cnt;
  logic [23:0] r_addr;
  logic        r_is_wr, r_nib, r_rd_pend;
  logic [7:0]  r_shift;
  logic [3:0]  r_lo, r_whi;

  logic                 r_sio_en, r_mem_req, r_mem_we;
  logic [3:0]           r_sio_o;
  logic [ADDR_BITS-1:0] r_mem_addr;
  logic [7:0]           r_mem_wdata;

  logic        w_rise, w_fall, w_ce_hi, w_ce_fall;
  logic [7:0]  w_cmd_next;
  logic        w_cmd_last, w_cmd_ok;
  logic [23:0] w_addr_next, w_addr_inc;
  logic [3:0]  w_dummy_n;
  logic        w_dummy_done, w_drive_hi;

  // Synchronizer resets to 0 so a ce_n already low at reset release is not
  // mistaken for a new falling edge.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_s1 <= 1'b0; r_sck_s2 <= 1'b0; r_sck_s3 <= 1'b0;
      r_ce_s1  <= 1'b0; r_ce_s2  <= 1'b0; r_ce_s3  <= 1'b0;
      r_sio_s1 <= 4'h0; r_sio_s2 <= 4'h0;
    end else begin
      r_sck_s1 <= sck;      r_sck_s2 <= r_sck_s1; r_sck_s3 <= r_sck_s2;
      r_ce_s1  <= ce_n;     r_ce_s2  <= r_ce_s1;  r_ce_s3  <= r_ce_s2;
      r_sio_s1 <= sio_i;    r_sio_s2 <= r_sio_s1;
    end
  end

  assign w_rise       = r_sck_s2 & ~r_sck_s3;
  assign w_fall       = ~r_sck_s2 & r_sck_s3;
  assign w_ce_hi      = r_ce_s2;
  assign w_ce_fall    = r_ce_s3 & ~r_ce_s2;
  assign w_cmd_next   = qspi_cmd ? {r_cmd[3:0], r_sio_s2} : {r_cmd, r_sio_s2[0]};
  assign w_cmd_last   = qspi_cmd ? (r_cnt == 4'd1) : (r_cnt == 4'd7);
  assign w_cmd_ok     = (w_cmd_next == 8'hEB) || (w_cmd_next == 8'h38);
  assign w_addr_next  = {r_addr[19:0], r_sio_s2};
  assign w_addr_inc   = r_addr + 24'd1;
  assign w_dummy_n    = (dummy == 4'd0) ? 4'd1 : dummy;
  assign w_dummy_done = (r_cnt == w_dummy_n);
  // Every high-nibble fall (including the one leaving DUMMY) also prefetches.
  assign w_drive_hi   = ~w_ce_hi & w_fall &
                        (((r_state == S_DUMMY) & w_dummy_done) |
                         ((r_state == S_RDATA) & ~r_nib));

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if ((r_state != S_IDLE) && w_ce_hi) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_ce_fall) w_next = S_CMD;
        S_CMD:   if (w_rise && w_cmd_last) w_next = w_cmd_ok ? S_ADDR : S_IGNORE;
        S_ADDR:  if (w_rise && (r_cnt == 4'd5)) w_next = r_is_wr ? S_WDATA : S_DUMMY;
        S_DUMMY: if (w_drive_hi) w_next = S_RDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= 7'h0; r_cnt <= 4'h0; r_addr <= 24'h0;
      r_is_wr <= 1'b0; r_nib <= 1'b0; r_rd_pend <= 1'b0;
      r_shift <= 8'h0; r_lo <= 4'h0; r_whi <= 4'h0;
      r_sio_o <= 4'h0; r_sio_en <= 1'b0;
      r_mem_req <= 1'b0; r_mem_we <= 1'b0;
      r_mem_addr <= '0; r_mem_wdata <= 8'h0;
    end else begin
      r_mem_req <= 1'b0;
      r_rd_pend <= r_mem_req & ~r_mem_we;
      if (r_rd_pend) r_shift <= mem_rdata;
      if (w_ce_hi || (r_state == S_IDLE)) begin
        r_cnt    <= 4'h0;
        r_nib    <= 1'b0;
        r_sio_en <= 1'b0;
      end else if (w_drive_hi) begin
        r_sio_en   <= 1'b1;
        r_sio_o    <= r_shift[7:4];
        r_lo       <= r_shift[3:0];
        r_nib      <= 1'b1;
        r_addr     <= w_addr_inc;
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= w_addr_inc[ADDR_BITS-1:0];
      end else begin
        case (r_state)
          S_CMD: if (w_rise) begin
            r_cmd <= w_cmd_next[6:0];
            r_cnt <= w_cmd_last ? 4'h0 : r_cnt + 4'd1;
            if (w_cmd_last) r_is_wr <= (w_cmd_next == 8'h38);
          end
          S_ADDR: if (w_rise) begin
            r_addr <= w_addr_next;
            r_cnt  <= (r_cnt == 4'd5) ? 4'h0 : r_cnt + 4'd1;
            if ((r_cnt == 4'd5) && !r_is_wr) begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= w_addr_next[ADDR_BITS-1:0];
            end
          end
          S_DUMMY: if (w_rise) r_cnt <= r_cnt + 4'd1;
          S_RDATA: if (w_fall) begin
            r_sio_o <= r_lo;
            r_nib   <= 1'b0;
          end
          S_WDATA: if (w_rise) begin
            if (!r_nib) begin
              r_whi <= r_sio_s2;
              r_nib <= 1'b1;
            end else begin
              r_nib       <= 1'b0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= {r_whi, r_sio_s2};
              r_mem_addr  <= r_addr[ADDR_BITS-1:0];
              r_addr      <= w_addr_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sio_o     = r_sio_o;
  assign sio_en    = r_sio_en;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed bench for qspi_mem_responder: table of whole transactions plus
// hand-written reset and abort sequences.
module tb_qspi_mem_responder;

  localparam int HALF = 8;

  logic        clkin = 1'b0;
  logic        rst_n, sck, ce_n, qspi_cmd;
  logic [3:0]  sio_i, dummy, sio_o;
  logic        sio_en, mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  qspi_mem_responder #(.ADDR_BITS(24)) dut (
    .clkin(clkin), .rst_n(rst_n), .sck(sck), .ce_n(ce_n), .sio_i(sio_i),
    .sio_o(sio_o), .sio_en(sio_en), .qspi_cmd(qspi_cmd), .dummy(dummy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clkin = ~clkin;

  logic [7:0] mem [logic [23:0]];

  function automatic logic [7:0] rd_mem(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  initial mem_rdata = 8'h00;
  always @(posedge clkin) if (mem_req && !mem_we) mem_rdata <= rd_mem(mem_addr);

  // Request log: {we, addr, wdata}; counters only ever grow.
  logic [32:0] log_q [256];
  int          log_total = 0;
  int          pulse_bad = 0;
  logic        prev_req = 1'b0;
  always @(negedge clkin) begin
    if (mem_req) begin
      log_q[log_total % 256] <= {mem_we, mem_addr, mem_wdata};
      log_total <= log_total + 1;
    end
    if (mem_req && prev_req) pulse_bad <= pulse_bad + 1;
    prev_req <= mem_req;
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clkin);
  endtask

  task automatic sck_cyc(input logic [3:0] nib, output logic [3:0] so, output logic se);
    sio_i = nib;
    half();
    so = sio_o; se = sio_en;
    sck = 1'b1;
    half();
    sck = 1'b0;
  endtask

  typedef struct {
    logic [1:0]       op;     // 0 write, 1 read, 2 unknown command
    logic             quad;
    logic [7:0]       cmd;
    logic [23:0]      addr;
    logic [3:0]       dm;
    logic [7:0]       d0, d1;
    int               n;
    logic [2:0][23:0] exp_a;
    logic             we;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic quad, input logic [7:0] cmd,
                              input logic [23:0] addr, input logic [3:0] dm,
                              input logic [7:0] d0, input logic [7:0] d1, input int n,
                              input logic [23:0] a0, input logic [23:0] a1,
                              input logic [23:0] a2, input logic we);
    vec_t v;
    v.op = op; v.quad = quad; v.cmd = cmd; v.addr = addr; v.dm = dm;
    v.d0 = d0; v.d1 = d1; v.n = n; v.exp_a = {a2, a1, a0}; v.we = we;
    return v;
  endfunction

  // Sends command and address; returns OR of sio_en seen before each rise.
  task automatic send_hdr(input logic quad, input logic [7:0] cmd, input logic [23:0] addr,
                          output logic en_seen);
    logic [3:0] so; logic se;
    en_seen = 1'b0;
    if (quad) begin
      sck_cyc(cmd[7:4], so, se); en_seen |= se;
      sck_cyc(cmd[3:0], so, se); en_seen |= se;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        sck_cyc({3'b000, cmd[i]}, so, se); en_seen |= se;
      end
    end
    for (int i = 5; i >= 0; i--) begin
      sck_cyc(addr[i*4 +: 4], so, se); en_seen |= se;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [3:0]  so; logic se, en_early, en_data;
    logic [15:0] nibs;
    logic [15:0] data;
    logic [32:0] e;
    int base, ndum;
    data = {v.d0, v.d1};
    if (v.op == 2'd1) begin
      mem[v.addr] = v.d0;
      mem[v.addr + 24'd1] = v.d1;
    end
    base = log_total;
    qspi_cmd = v.quad; dummy = v.dm; sck = 1'b0;
    @(negedge clkin); ce_n = 1'b0;
    half();
    send_hdr(v.quad, v.cmd, v.addr, en_early);
    nibs = 16'h0; en_data = 1'b1;
    if (v.op == 2'd1) begin
      ndum = (v.dm == 4'd0) ? 1 : int'(v.dm);
      for (int i = 0; i < ndum; i++) begin
        sck_cyc(4'h0, so, se); en_early |= se;
      end
      for (int k = 0; k < 4; k++) begin
        sio_i = 4'h0;
        half();
        nibs = {nibs[11:0], sio_o};
        en_data &= sio_en;
        sck = 1'b1;
        half();
        if (k == 3) begin
          ce_n = 1'b1;
          half();
        end
        sck = 1'b0;
      end
    end else begin
      for (int k = 3; k >= 0; k--) begin
        sck_cyc(data[k*4 +: 4], so, se); en_early |= se;
      end
      ce_n = 1'b1;
    end
    repeat (12) @(negedge clkin);
    check($sformatf("v%0d_nreq", idx), log_total - base, v.n);
    for (int k = 0; k < v.n && k < 3; k++) begin
      e = log_q[(base + k) % 256];
      check($sformatf("v%0d_addr%0d", idx, k), e[31:8], v.exp_a[k]);
      check($sformatf("v%0d_we%0d", idx, k), e[32], v.we);
      if (v.we) check($sformatf("v%0d_wdata%0d", idx, k), e[7:0], (k == 0) ? v.d0 : v.d1);
    end
    check($sformatf("v%0d_en_early", idx), en_early, 1'b0);
    if (v.op == 2'd1) begin
      check($sformatf("v%0d_nibs", idx), nibs, data);
      check($sformatf("v%0d_en_data", idx), en_data, 1'b1);
    end
    check($sformatf("v%0d_en_after", idx), sio_en, 1'b0);
  endtask

  function automatic logic [63:0] outs();
    return {27'h0, sio_o, sio_en, mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  vec_t vecs [7];

  initial begin
    logic [3:0] so; logic se, en_seen;
    int base, pb0;

    vecs[0] = mk(2'd0, 1'b1, 8'h38, 24'h000010, 4'd0, 8'hA5, 8'h3C, 2,
                 24'h000010, 24'h000011, 24'h0, 1'b1);
    vecs[1] = mk(2'd1, 1'b0, 8'hEB, 24'h000010, 4'd4, 8'hA5, 8'h3C, 3,
                 24'h000010, 24'h000011, 24'h000012, 1'b0);
    vecs[2] = mk(2'd1, 1'b1, 8'hEB, 24'hFFFFFF, 4'd2, 8'h5A, 8'hC3, 3,
                 24'hFFFFFF, 24'h000000, 24'h000001, 1'b0);
    vecs[3] = mk(2'd1, 1'b0, 8'hEB, 24'h000123, 4'd0, 8'h81, 8'h7E, 3,
                 24'h000123, 24'h000124, 24'h000125, 1'b0);
    vecs[4] = mk(2'd1, 1'b0, 8'hEB, 24'h000123, 4'd1, 8'h81, 8'h7E, 3,
                 24'h000123, 24'h000124, 24'h000125, 1'b0);
    vecs[5] = mk(2'd2, 1'b1, 8'h9F, 24'h000010, 4'd0, 8'h12, 8'h34, 0,
                 24'h0, 24'h0, 24'h0, 1'b0);
    vecs[6] = mk(2'd0, 1'b0, 8'h38, 24'hABCDEF, 4'd0, 8'h00, 8'hFF, 2,
                 24'hABCDEF, 24'hABCDF0, 24'h0, 1'b1);

    rst_n = 1'b0; ce_n = 1'b1; sck = 1'b0; sio_i = 4'h0; qspi_cmd = 1'b0; dummy = 4'd0;
    repeat (3) @(negedge clkin);
    check("reset_outs", outs(), 64'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clkin);
    check("idle_outs", outs(), 64'h0);

    // Reset while RDATA is driving: outputs clear without waiting for a clock.
    mem[24'h000020] = 8'h96; mem[24'h000021] = 8'h69;
    qspi_cmd = 1'b0; dummy = 4'd1;
    ce_n = 1'b0; half();
    send_hdr(1'b0, 8'hEB, 24'h000020, en_seen);
    sck_cyc(4'h0, so, se);
    half();
    check("rst_pre_nib", {sio_en, sio_o}, {1'b1, 4'h9});
    #2 rst_n = 1'b0;
    #1 check("rst_async_outs", outs(), 64'h0);
    repeat (3) @(negedge clkin);
    rst_n = 1'b1;
    base = log_total; en_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sck_cyc(4'hE, so, se); en_seen |= se;
    end
    check("rst_post_en", en_seen, 1'b0);
    check("rst_post_nreq", log_total - base, 0);
    ce_n = 1'b1;
    repeat (12) @(negedge clkin);

    pb0 = pulse_bad;
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Write aborted after the high nibble of the first byte.
    base = log_total;
    qspi_cmd = 1'b1; @(negedge clkin); ce_n = 1'b0; half();
    send_hdr(1'b1, 8'h38, 24'h000040, en_seen);
    sck_cyc(4'hA, so, se);
    ce_n = 1'b1;
    repeat (16) @(negedge clkin);
    check("abort_wr_nreq", log_total - base, 0);

    // Read aborted while driving data.
    mem[24'h000030] = 8'hD2; mem[24'h000031] = 8'h4B;
    qspi_cmd = 1'b1; dummy = 4'd1;
    @(negedge clkin); ce_n = 1'b0; half();
    send_hdr(1'b1, 8'hEB, 24'h000030, en_seen);
    sck_cyc(4'h0, so, se);
    sck_cyc(4'h0, so, se);
    check("abort_rd_pre", {se, so}, {1'b1, 4'hD});
    half();
    ce_n = 1'b1;
    repeat (4) @(negedge clkin);
    check("abort_rd_en", sio_en, 1'b0);
    repeat (12) @(negedge clkin);

    check("req_single_pulse", pulse_bad - pb0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
